seq_signed_divider: RTL



---
 rtl/seq_signed_divider.sv | 119 +++++++++++
 1 files changed

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per clock,
// followed by sign correction. States: IDLE (wait for start) | CALC (N restoring steps) | FIX (register result).
module seq_signed_divider #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_valid,
  output logic         o_busy,
  output logic         o_dbz,
  output logic         o_ovf
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_dvd;
  logic [N-1:0]  r_dsr;
  logic [CW-1:0] r_cnt;
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_dbz;
  logic          r_ovf;

  logic [N-1:0]  w_dvd_abs;
  logic [N-1:0]  w_dsr_abs;
  logic [N-1:0]  w_min;
  logic [N:0]    w_shift;
  logic [N-1:0]  w_diff;
  logic          w_ge;

  assign w_dvd_abs = i_dividend[N-1] ? (~i_dividend + 1'b1) : i_dividend;
  assign w_dsr_abs = i_divisor[N-1]  ? (~i_divisor + 1'b1)  : i_divisor;
  assign w_min     = {1'b1, {(N-1){1'b0}}};

  // The partial remainder always stays below 2^(N-1) after a step, so the
  // shifted value fits N+1 bits and an accepted difference fits N bits.
  assign w_shift = {r_rem, r_dvd[N-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dsr});
  assign w_diff  = w_shift[N-1:0] - r_dsr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_dbz       <= 1'b0;
      o_ovf       <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_dvd   <= w_dvd_abs;
            r_dsr   <= w_dsr_abs;
            r_rem   <= '0;
            r_cnt   <= CW'(N - 1);
            r_neg_q <= i_dividend[N-1] ^ i_divisor[N-1];
            r_neg_r <= i_dividend[N-1];
            r_dbz   <= (i_divisor == '0);
            r_ovf   <= (i_dividend == w_min) && (i_divisor == '1);
            o_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_diff : w_shift[N-1:0];
          r_dvd <= {r_dvd[N-2:0], w_ge};
          if (r_cnt == '0) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          // A zero divisor yields remainder = |dividend| naturally; only the quotient is forced.
          if (r_dbz) begin
            o_quotient <= '1;
          end else begin
            o_quotient <= r_neg_q ? (~r_dvd + 1'b1) : r_dvd;
          end
          o_remainder <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
          o_dbz       <= r_dbz;
          o_ovf       <= r_ovf;
          o_valid     <= 1'b1;
          o_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
